// File: rtl/ws2811_pkg.sv
// ws2811_pkg
// Shared definitions for the WS2811 strip driver: pixel width, default
// timing constants (in CLKIN cycles), the controller state encoding and a
// helper that sizes the frame-RAM address so a one-pixel strip still gets
// a 1-bit address bus.
package ws2811_pkg;

   localparam int PIXEL_W        = 24;

   localparam int DEF_NUM_CH     = 8;
   localparam int DEF_NUM_PIXELS = 64;
   localparam int DEF_T_BIT      = 15;
   localparam int DEF_T0H        = 3;
   localparam int DEF_T1H        = 7;
   localparam int DEF_T_RESET    = 600;

   localparam logic [1:0] STATE_IDLE  = 2'd0;
   localparam logic [1:0] STATE_FETCH = 2'd1;
   localparam logic [1:0] STATE_SEND  = 2'd2;
   localparam logic [1:0] STATE_LATCH = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = STATE_IDLE,
      ST_FETCH = STATE_FETCH,
      ST_SEND  = STATE_SEND,
      ST_LATCH = STATE_LATCH
   } state_e;

   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ws2811_strip_driver_if.sv
// ws2811_strip_driver_if
// Bundles the frame handshake, frame-RAM read port and LED outputs.
//   START  frame request pulse           (master -> slave)
//   RADDR  pixel address to frame RAM    (slave  -> master)
//   RDATA  pixel word, lane c = [24c+23:24c], valid one cycle after RADDR
//   DOUT   serial LED data, one bit per strip
//   BUSY   frame in progress
//   DONE   one-cycle pulse at frame completion
// The slave modport is the driver; the master modport is the frame source.
interface ws2811_strip_driver_if
   import ws2811_pkg::*;
#(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int NUM_PIXELS = DEF_NUM_PIXELS
) ();

   localparam int AW = addr_w(NUM_PIXELS);

   logic                        START;
   logic [AW-1:0]               RADDR;
   logic [PIXEL_W*NUM_CH-1:0]   RDATA;
   logic [NUM_CH-1:0]           DOUT;
   logic                        BUSY;
   logic                        DONE;

   modport master (
      output START, RDATA,
      input  RADDR, DOUT, BUSY, DONE
   );

   modport slave (
      input  START, RDATA,
      output RADDR, DOUT, BUSY, DONE
   );

endinterface

// File: rtl/ws2811_bit_timer.sv
// ws2811_bit_timer
// Phase counter for one WS2811 bit period, shared by every channel so all
// strips stay bit-synchronous. Counts 0..T_BIT-1 while run is high and sits
// at 0 otherwise, so the first run cycle is always phase 0.
// Strobes are combinational from the phase and mark the *current* cycle:
//   bit_start  phase 0
//   high0_end  last high cycle of a 0 bit (phase T0H-1)
//   high1_end  last high cycle of a 1 bit (phase T1H-1)
//   bit_end    last cycle of the bit period (phase T_BIT-1)
// Ports: clk, rst_n (async active-low), run.
module ws2811_bit_timer #(
   parameter int T_BIT = 15,
   parameter int T0H   = 3,
   parameter int T1H   = 7
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic bit_start,
   output logic high0_end,
   output logic high1_end,
   output logic bit_end
);

   localparam int PW = $clog2(T_BIT);
   localparam logic [PW-1:0] PH_LAST = PW'(T_BIT - 1);
   localparam logic [PW-1:0] PH_H0   = PW'(T0H - 1);
   localparam logic [PW-1:0] PH_H1   = PW'(T1H - 1);

   logic [PW-1:0] phase_q, phase_d;

   // Advance within the bit period, wrap at the end, park at 0 when idle.
   always_comb begin
      phase_d = '0;
      if (run && (phase_q != PH_LAST)) begin
         phase_d = phase_q + 1'b1;
      end
   end

   // Phase register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign bit_start = run && (phase_q == '0);
   assign high0_end = run && (phase_q == PH_H0);
   assign high1_end = run && (phase_q == PH_H1);
   assign bit_end   = run && (phase_q == PH_LAST);

endmodule

// File: rtl/ws2811_strip_driver.sv
// ws2811_strip_driver
// Streams a frame of 24-bit pixels from a synchronous frame RAM to NUM_CH
// WS2811 strips in parallel, MSB first, then holds the lines low for the
// latch gap. Next-pixel words are prefetched during bit 0 of the current
// pixel so pixels follow each other with no idle cycles.
// Ports: CLKIN, RESETN (async active-low), bus (slave modport of
// ws2811_strip_driver_if: START, RADDR, RDATA, DOUT, BUSY, DONE).
// Build option: define WS2811_AUTOREFRESH_EN to restart the frame from
// pixel 0 after every latch gap (DONE still pulses, BUSY stays high).
module ws2811_strip_driver
   import ws2811_pkg::*;
#(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int NUM_PIXELS = DEF_NUM_PIXELS,
   parameter int T_BIT      = DEF_T_BIT,
   parameter int T0H        = DEF_T0H,
   parameter int T1H        = DEF_T1H,
   parameter int T_RESET    = DEF_T_RESET
) (
   input  logic                  CLKIN,
   input  logic                  RESETN,
   ws2811_strip_driver_if.slave  bus
);

   localparam int AW = addr_w(NUM_PIXELS);
   localparam int LW = $clog2(T_RESET + 1);
   localparam logic [AW-1:0] LAST_PX    = AW'(NUM_PIXELS - 1);
   localparam logic [LW-1:0] LATCH_LAST = LW'(T_RESET - 1);
   localparam logic [4:0]    TOP_BIT    = 5'(PIXEL_W - 1);

   if (T0H < 1 || T1H <= T0H || T_BIT <= T1H || T_BIT < 4) begin : g_bad_timing
      $error("ws2811_strip_driver: need 1 <= T0H < T1H < T_BIT and T_BIT >= 4");
   end
   if (NUM_PIXELS < 1 || NUM_PIXELS > 4096) begin : g_bad_pixels
      $error("ws2811_strip_driver: NUM_PIXELS must be 1..4096");
   end
   if (NUM_CH < 1 || T_RESET < 1) begin : g_bad_misc
      $error("ws2811_strip_driver: NUM_CH and T_RESET must be at least 1");
   end

   state_e                           state_q, state_d;
   logic                             fetch_cnt_q, fetch_cnt_d;
   logic [AW-1:0]                    px_q, px_d;
   logic [AW-1:0]                    raddr_q, raddr_d;
   logic [4:0]                       bit_q, bit_d;
   logic [LW-1:0]                    latch_q, latch_d;
   logic [NUM_CH-1:0][PIXEL_W-1:0]   shift_q, shift_d;
   logic [NUM_CH-1:0][PIXEL_W-1:0]   shadow_q, shadow_d;
   logic                             capture_q, capture_d;
   logic [NUM_CH-1:0]                dout_q, dout_d;
   logic                             busy_q, busy_d;
   logic                             done_q, done_d;

   logic bit_start, high0_end, high1_end, bit_end;

   ws2811_bit_timer #(
      .T_BIT (T_BIT),
      .T0H   (T0H),
      .T1H   (T1H)
   ) u_bit_timer (
      .clk       (CLKIN),
      .rst_n     (RESETN),
      .run       (state_q == ST_SEND),
      .bit_start (bit_start),
      .high0_end (high0_end),
      .high1_end (high1_end),
      .bit_end   (bit_end)
   );

   // Frame sequencing. DOUT is registered, so every decision below sets the
   // line level for the *next* cycle: it goes high at each bit boundary and
   // drops after the last high cycle of the bit being sent.
   always_comb begin
      state_d     = state_q;
      fetch_cnt_d = fetch_cnt_q;
      px_d        = px_q;
      raddr_d     = raddr_q;
      bit_d       = bit_q;
      latch_d     = latch_q;
      shift_d     = shift_q;
      shadow_d    = shadow_q;
      dout_d      = dout_q;
      // RADDR moved at phase 0 of bit 0; the RAM answer is stable by the
      // end of phase 1, which is when the shadow copy is taken.
      capture_d   = bit_start && (bit_q == 5'd0);
      if (capture_q) begin
         shadow_d = bus.RDATA;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.START) begin
               state_d     = ST_FETCH;
               fetch_cnt_d = 1'b0;
               px_d        = '0;
               raddr_d     = '0;
            end
         end

         ST_FETCH: begin
            if (fetch_cnt_q) begin
               state_d = ST_SEND;
               shift_d = bus.RDATA;
               bit_d   = TOP_BIT;
               dout_d  = '1;
            end else begin
               fetch_cnt_d = 1'b1;
            end
         end

         ST_SEND: begin
            if (high0_end) begin
               for (int c = 0; c < NUM_CH; c++) begin
                  if (!shift_q[c][PIXEL_W-1]) begin
                     dout_d[c] = 1'b0;
                  end
               end
            end
            if (high1_end) begin
               dout_d = '0;
            end
            if (bit_end) begin
               if (bit_q == 5'd1 && px_q != LAST_PX) begin
                  raddr_d = px_q + 1'b1;
               end
               if (bit_q != 5'd0) begin
                  bit_d = bit_q - 5'd1;
                  for (int c = 0; c < NUM_CH; c++) begin
                     shift_d[c] = {shift_q[c][PIXEL_W-2:0], 1'b0};
                  end
                  dout_d = '1;
               end else if (px_q != LAST_PX) begin
                  px_d    = px_q + 1'b1;
                  bit_d   = TOP_BIT;
                  shift_d = shadow_q;
                  dout_d  = '1;
               end else begin
                  state_d = ST_LATCH;
                  latch_d = '0;
                  dout_d  = '0;
               end
            end
         end

         ST_LATCH: begin
            if (latch_q == LATCH_LAST) begin
`ifdef WS2811_AUTOREFRESH_EN
               state_d     = ST_FETCH;
               fetch_cnt_d = 1'b0;
               px_d        = '0;
`else
               state_d     = ST_IDLE;
`endif
               raddr_d = '0;
            end else begin
               latch_d = latch_q + 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // DONE is registered and must coincide with the final latch cycle.
      done_d = (state_d == ST_LATCH) && (latch_d == LATCH_LAST);
      busy_d = (state_d != ST_IDLE);
   end

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge CLKIN or negedge RESETN) begin
      if (!RESETN) begin
         state_q     <= ST_IDLE;
         fetch_cnt_q <= 1'b0;
         px_q        <= '0;
         raddr_q     <= '0;
         bit_q       <= '0;
         latch_q     <= '0;
         shift_q     <= '0;
         shadow_q    <= '0;
         capture_q   <= 1'b0;
         dout_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_cnt_q <= fetch_cnt_d;
         px_q        <= px_d;
         raddr_q     <= raddr_d;
         bit_q       <= bit_d;
         latch_q     <= latch_d;
         shift_q     <= shift_d;
         shadow_q    <= shadow_d;
         capture_q   <= capture_d;
         dout_q      <= dout_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.RADDR = raddr_q;
   assign bus.DOUT  = dout_q;
   assign bus.BUSY  = busy_q;
   assign bus.DONE  = done_q;

endmodule

// File: tb/tb_ws2811_strip_driver.sv
// tb_ws2811_strip_driver
// Drives two driver instances (2 lanes x 3 pixels, and 2 lanes x 1 pixel)
// from behavioural frame RAMs and compares every cycle against a waveform
// model built directly from the WS2811 framing rules.
module tb_ws2811_strip_driver;

   localparam int NCH   = 2;
   localparam int NPX_A = 3;
   localparam int NPX_B = 1;
   localparam int TBIT  = 15;
   localparam int TH0   = 3;
   localparam int TH1   = 7;
   localparam int TRST  = 600;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   int   sel = 0;

   logic [47:0] frame_q[$];
   logic [47:0] ram_a [NPX_A];
   logic [47:0] ram_b [NPX_B];

   logic [1:0]  o_dout;
   logic        o_busy;
   logic        o_done;
   logic [63:0] o_raddr;

   always #5 clk = ~clk;

   ws2811_strip_driver_if #(.NUM_CH(NCH), .NUM_PIXELS(NPX_A)) bus_a ();
   ws2811_strip_driver_if #(.NUM_CH(NCH), .NUM_PIXELS(NPX_B)) bus_b ();

   ws2811_strip_driver #(
      .NUM_CH(NCH), .NUM_PIXELS(NPX_A), .T_BIT(TBIT),
      .T0H(TH0), .T1H(TH1), .T_RESET(TRST)
   ) dut_a (
      .CLKIN  (clk),
      .RESETN (rst_n),
      .bus    (bus_a.slave)
   );

   ws2811_strip_driver #(
      .NUM_CH(NCH), .NUM_PIXELS(NPX_B), .T_BIT(TBIT),
      .T0H(TH0), .T1H(TH1), .T_RESET(TRST)
   ) dut_b (
      .CLKIN  (clk),
      .RESETN (rst_n),
      .bus    (bus_b.slave)
   );

   // Synchronous frame RAMs: data appears the cycle after the address.
   always @(posedge clk) begin
      bus_a.RDATA <= (int'(bus_a.RADDR) < NPX_A) ? ram_a[int'(bus_a.RADDR)] : 48'h0;
      bus_b.RDATA <= (int'(bus_b.RADDR) < NPX_B) ? ram_b[int'(bus_b.RADDR)] : 48'h0;
   end

   // Observe whichever instance the current scenario is exercising.
   always_comb begin
      if (sel == 1) begin
         o_dout  = bus_b.DOUT;
         o_busy  = bus_b.BUSY;
         o_done  = bus_b.DONE;
         o_raddr = 64'(bus_b.RADDR);
      end else begin
         o_dout  = bus_a.DOUT;
         o_busy  = bus_a.BUSY;
         o_done  = bus_a.DONE;
         o_raddr = 64'(bus_a.RADDR);
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Expected outputs k cycles after the START-accepting edge (k=0 is the
   // first cycle after it), derived from: 2 fetch cycles, 24*T_BIT cycles
   // per pixel MSB first, T_RESET latch cycles with DONE on the last one,
   // and the next pixel's address appearing when bit 0 of a pixel begins.
   function automatic void modelAt(input int k, output logic [1:0] e_dout,
                                   output logic e_busy, output logic e_done,
                                   output int e_raddr);
      int n, pix_cyc, len, kk, s, p, b, ph;
      logic [47:0] w;
      n       = frame_q.size();
      pix_cyc = 24 * TBIT;
      len     = 2 + n * pix_cyc + TRST;
      e_dout  = 2'b00;
      e_done  = 1'b0;
      e_raddr = 0;
`ifdef WS2811_AUTOREFRESH_EN
      kk     = k % len;
      e_busy = 1'b1;
`else
      kk     = k;
      e_busy = (k < len);
      if (k >= len) return;
`endif
      e_done = (kk == len - 1);
      if (kk >= 2 && kk < 2 + n * pix_cyc) begin
         s  = kk - 2;
         p  = s / pix_cyc;
         b  = 23 - (s % pix_cyc) / TBIT;
         ph = s % TBIT;
         w  = frame_q[p];
         for (int lane = 0; lane < NCH; lane++) begin
            e_dout[lane] = (ph < (w[lane*24 + b] ? TH1 : TH0));
         end
      end
      for (int q = 1; q < n; q++) begin
         if (kk >= 2 + (q - 1) * pix_cyc + 23 * TBIT) e_raddr = q;
      end
   endfunction

   task automatic setStart(input int which, input logic v);
      if (which == 1) bus_b.START = v;
      else            bus_a.START = v;
   endtask

   // Pull reset at a negedge and confirm it clears the outputs at once and
   // that no DONE slips out afterwards.
   task automatic doReset();
      rst_n = 1'b0;
      bus_a.START = 1'b0;
      bus_b.START = 1'b0;
      #1;
      checkOutput("rst_dout_now",  64'(o_dout),  64'd0);
      checkOutput("rst_busy_now",  64'(o_busy),  64'd0);
      checkOutput("rst_done_now",  64'(o_done),  64'd0);
      checkOutput("rst_raddr_now", o_raddr,      64'd0);
      repeat (3) begin
         @(negedge clk);
         checkOutput("rst_hold_busy", 64'(o_busy), 64'd0);
         checkOutput("rst_hold_done", 64'(o_done), 64'd0);
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         checkOutput("post_rst_busy", 64'(o_busy), 64'd0);
         checkOutput("post_rst_done", 64'(o_done), 64'd0);
         checkOutput("post_rst_dout", 64'(o_dout), 64'd0);
      end
   endtask

   // Run one frame from frame_q on the chosen instance, optionally
   // re-pulsing START at cycle glitch_at or resetting at cycle reset_at.
   task automatic applyStimulus(input int which, input int glitch_at, input int reset_at);
      int n, len, limit, done_k, e_raddr;
      logic [1:0] e_dout;
      logic e_busy, e_done;
      bit aborted;
      sel     = which;
      n       = frame_q.size();
      len     = 2 + 24 * n * TBIT + TRST;
      done_k  = -1;
      aborted = 1'b0;
      for (int p = 0; p < n; p++) begin
         if (which == 1) ram_b[p] = frame_q[p];
         else            ram_a[p] = frame_q[p];
      end
`ifdef WS2811_AUTOREFRESH_EN
      limit = 2 * len + 5;
`else
      limit = len + 4;
`endif
      @(negedge clk);
      setStart(which, 1'b1);
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < limit; k++) begin
         if (k == reset_at) begin
            doReset();
            aborted = 1'b1;
            break;
         end
         setStart(which, k == glitch_at);
         modelAt(k, e_dout, e_busy, e_done, e_raddr);
         checkOutput($sformatf("dout@%0d", k),  64'(o_dout), 64'(e_dout));
         checkOutput($sformatf("busy@%0d", k),  64'(o_busy), 64'(e_busy));
         checkOutput($sformatf("done@%0d", k),  64'(o_done), 64'(e_done));
         checkOutput($sformatf("raddr@%0d", k), o_raddr,     64'(e_raddr));
         if (o_done && done_k < 0) done_k = k;
         @(negedge clk);
      end
      setStart(which, 1'b0);
      if (!aborted) begin
         checkOutput("done_latency", 64'(done_k + 1), 64'(len));
`ifdef WS2811_AUTOREFRESH_EN
         doReset();
`endif
      end
   endtask

   function automatic logic [47:0] randWord();
      return 48'({$urandom(), $urandom()});
   endfunction

   initial begin
      rst_n       = 1'b0;
      bus_a.START = 1'b0;
      bus_b.START = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy_a",  64'(bus_a.BUSY),  64'd0);
      checkOutput("reset_done_a",  64'(bus_a.DONE),  64'd0);
      checkOutput("reset_dout_a",  64'(bus_a.DOUT),  64'd0);
      checkOutput("reset_raddr_a", 64'(bus_a.RADDR), 64'd0);
      checkOutput("reset_busy_b",  64'(bus_b.BUSY),  64'd0);
      checkOutput("reset_dout_b",  64'(bus_b.DOUT),  64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("idle_busy_a", 64'(bus_a.BUSY), 64'd0);

      $display("[TB] lane0 0xFF0000 / lane1 0x00FF00 frame");
      frame_q = {};
      repeat (NPX_A) frame_q.push_back({24'h00FF00, 24'hFF0000});
      applyStimulus(0, -1, -1);

      $display("[TB] alternating pattern across pixel boundaries");
      frame_q = {};
      frame_q.push_back({24'hAAAAAA, 24'hAAAAAA});
      frame_q.push_back({24'h555555, 24'h555555});
      frame_q.push_back({24'h000001, 24'h000001});
      applyStimulus(0, -1, -1);

      $display("[TB] START re-asserted mid-frame");
      frame_q = {};
      repeat (NPX_A) frame_q.push_back(randWord());
      applyStimulus(0, 100, -1);

      $display("[TB] reset mid-frame, then a fresh frame");
      frame_q = {};
      repeat (NPX_A) frame_q.push_back(randWord());
      applyStimulus(0, -1, 500);
      frame_q = {};
      repeat (NPX_A) frame_q.push_back(randWord());
      applyStimulus(0, -1, -1);

      $display("[TB] single-pixel strip");
      frame_q = {};
      frame_q.push_back(randWord());
      applyStimulus(1, -1, -1);

      $display("[TB] random frames");
      repeat (2) begin
         frame_q = {};
         repeat (NPX_A) frame_q.push_back(randWord());
         applyStimulus(0, -1, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
